irq_tick_gen: RTL and testbench

Programmable periodic interrupt generator for the PL side of the Zynq design, clocked by the PS-supplied `axi_aclk`. It drives a level-sensitive fabric interrupt into the PS (IRQ_F2P, serviced through the SCUGIC) and keeps a 16-bit fired-event count. Software reads that count over GPIO to check interrupt latency and detect missed interrupts. Period and enable come from PL GPIO outputs; the acknowledge is a one-cycle pulse decoded from a GPIO write.

---
 rtl/irq_tick_gen.sv | 113 +++++++++++
 tb/tb_irq_tick_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_tick_gen.sv
// irq_tick_gen: programmable periodic interrupt generator.
// Drives a level interrupt into the PS every eff_period cycles of axi_aclk,
// where eff_period = max(period, 2). A pending interrupt stays high until
// software acknowledges it. icount counts every fire event and wraps.
// Optional feature macro: IRQ_TICK_OVERRUN_EN. When it is defined,
// overrun_count counts fires that land while irq is already high, and
// saturates at all-ones. When it is undefined, overrun_count is tied to 0
// and no overrun register is built.

module irq_tick_gen #(
   parameter int PERIOD_W = 32,
   parameter int ICOUNT_W = 16
) (
   input  logic                axi_aclk,
   input  logic                axi_aresetn,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic                irq_ack,
   output logic                irq,
   output logic [ICOUNT_W-1:0] icount,
   output logic [ICOUNT_W-1:0] overrun_count,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t              state;
   logic [PERIOD_W-1:0] count;
   logic [PERIOD_W-1:0] reload_val;
   logic                fire;

   // Reload value is eff_period-1 taken from the live period input; periods
   // of 0 and 1 are clamped to 2. A fire is the terminal count while running.
   always_comb begin
      reload_val = period - PERIOD_W'(1);
      if (period < PERIOD_W'(2)) begin
         reload_val = PERIOD_W'(1);
      end
      fire = (state != IDLE) && (count == '0);
   end

   // Main FSM with down-counter, registered irq/busy and the fired-event count.
   // Disable beats fire, and fire beats ack so a same-cycle ack cannot lose an event.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state  <= IDLE;
         count  <= '0;
         irq    <= 1'b0;
         busy   <= 1'b0;
         icount <= '0;
      end else begin
         case (state)
            IDLE: begin
               irq <= 1'b0;
               if (enable) begin
                  state <= RUN;
                  count <= reload_val;
                  busy  <= 1'b1;
               end
            end
            RUN, PEND: begin
               if (!enable) begin
                  state <= IDLE;
                  count <= '0;
                  irq   <= 1'b0;
                  busy  <= 1'b0;
               end else if (fire) begin
                  state  <= PEND;
                  count  <= reload_val;
                  irq    <= 1'b1;
                  icount <= icount + ICOUNT_W'(1);
               end else begin
                  count <= count - PERIOD_W'(1);
                  if ((state == PEND) && irq_ack) begin
                     state <= RUN;
                     irq   <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
               irq   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef IRQ_TICK_OVERRUN_EN
   logic [ICOUNT_W-1:0] overrun_q;

   // Count fires that hit an unacknowledged interrupt; a same-cycle ack
   // consumes the old event, so that case is not an overrun. Saturates.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         overrun_q <= '0;
      end else if (enable && fire && (state == PEND) && !irq_ack
                   && (overrun_q != '1)) begin
         overrun_q <= overrun_q + ICOUNT_W'(1);
      end
   end

   assign overrun_count = overrun_q;
`else
   assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_irq_tick_gen.sv
// tb_irq_tick_gen: directed self-checking bench for irq_tick_gen.
// The DUT is built with an 8-bit event counter so that icount wrap and
// overrun saturation are reachable in a short run. Expected values in the
// overrun checks depend on whether IRQ_TICK_OVERRUN_EN is defined.

module tb_irq_tick_gen;

   localparam int PERIOD_W = 32;
   localparam int ICOUNT_W = 8;

`ifdef IRQ_TICK_OVERRUN_EN
   localparam bit OVR_ON = 1'b1;
`else
   localparam bit OVR_ON = 1'b0;
`endif

   logic                axi_aclk    = 1'b0;
   logic                axi_aresetn = 1'b0;
   logic                enable      = 1'b0;
   logic [PERIOD_W-1:0] period      = '0;
   logic                irq_ack     = 1'b0;
   logic                irq;
   logic [ICOUNT_W-1:0] icount;
   logic [ICOUNT_W-1:0] overrun_count;
   logic                busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   irq_tick_gen #(
      .PERIOD_W(PERIOD_W),
      .ICOUNT_W(ICOUNT_W)
   ) dut (
      .axi_aclk     (axi_aclk),
      .axi_aresetn  (axi_aresetn),
      .enable       (enable),
      .period       (period),
      .irq_ack      (irq_ack),
      .irq          (irq),
      .icount       (icount),
      .overrun_count(overrun_count),
      .busy         (busy)
   );

   // 100 MHz clock
   always #5 axi_aclk = ~axi_aclk;

   // Advance one clock and sample 1ns after the edge.
   task automatic tick();
      @(posedge axi_aclk);
      #1;
      cyc++;
   endtask

   // Run until the cycle counter (relative to the enable edge) reaches target.
   task automatic advanceTo(input int target);
      while (cyc < target) tick();
   endtask

   task automatic applyStimulus(input logic en, input logic [PERIOD_W-1:0] per,
                                input logic ack);
      enable  = en;
      period  = per;
      irq_ack = ack;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int ovrExp(input int v);
      return OVR_ON ? v : 0;
   endfunction

   // Linear sequence of directed steps.
   initial begin
      // Reset held, then released with enable low for 100 cycles
      applyStimulus(1'b0, 32'd0, 1'b0);
      axi_aresetn = 1'b0;
      repeat (3) @(posedge axi_aclk);
      #1;
      checkOutput("rst_irq", {31'd0, irq}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_icount", 32'(icount), 32'd0);
      checkOutput("rst_ovr", 32'(overrun_count), 32'd0);
      #2;
      axi_aresetn = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         checkOutput("idle_irq", {31'd0, irq}, 32'd0);
         checkOutput("idle_busy", {31'd0, busy}, 32'd0);
         checkOutput("idle_icount", 32'(icount), 32'd0);
      end

      // Basic period 10, ack three cycles after each rise, five events
      applyStimulus(1'b1, 32'd10, 1'b0);
      tick();
      cyc = 0;
      checkOutput("basic_busy", {31'd0, busy}, 32'd1);
      checkOutput("basic_irq0", {31'd0, irq}, 32'd0);
      for (int k = 1; k <= 50; k++) begin
         tick();
         checkOutput("basic_irq", {31'd0, irq},
                     ((k >= 10) && ((k % 10) <= 2)) ? 32'd1 : 32'd0);
         checkOutput("basic_icount", 32'(icount), 32'(k / 10));
         irq_ack = ((k % 10) == 2) ? 1'b1 : 1'b0;
      end
      checkOutput("basic_ovr", 32'(overrun_count), 32'd0);

      // Disable while irq is high
      applyStimulus(1'b0, 32'd10, 1'b0);
      tick();
      checkOutput("dis_irq", {31'd0, irq}, 32'd0);
      checkOutput("dis_busy", {31'd0, busy}, 32'd0);
      checkOutput("dis_icount", 32'(icount), 32'd5);
      repeat (5) tick();
      checkOutput("dis_hold_icount", 32'(icount), 32'd5);
      checkOutput("dis_hold_irq", {31'd0, irq}, 32'd0);

      // Simultaneous ack and fire, period 8
      applyStimulus(1'b1, 32'd8, 1'b0);
      tick();
      cyc = 0;
      advanceTo(7);
      checkOutput("af_irq_pre", {31'd0, irq}, 32'd0);
      advanceTo(8);
      checkOutput("af_irq_first", {31'd0, irq}, 32'd1);
      checkOutput("af_icount_first", 32'(icount), 32'd6);
      advanceTo(15);
      irq_ack = 1'b1;
      advanceTo(16);
      irq_ack = 1'b0;
      checkOutput("af_irq_same", {31'd0, irq}, 32'd1);
      checkOutput("af_icount_same", 32'(icount), 32'd7);
      checkOutput("af_ovr_same", 32'(overrun_count), 32'd0);
      advanceTo(17);
      irq_ack = 1'b1;
      advanceTo(18);
      irq_ack = 1'b0;
      checkOutput("af_irq_acked", {31'd0, irq}, 32'd0);
      checkOutput("af_busy", {31'd0, busy}, 32'd1);
      advanceTo(24);
      checkOutput("af_irq_third", {31'd0, irq}, 32'd1);
      checkOutput("af_icount_third", 32'(icount), 32'd8);
      checkOutput("af_ovr_third", 32'(overrun_count), 32'd0);
      advanceTo(32);
      checkOutput("af_icount_fourth", 32'(icount), 32'd9);
      checkOutput("af_ovr_fourth", 32'(overrun_count), 32'(ovrExp(1)));
      applyStimulus(1'b0, 32'd8, 1'b0);
      tick();

      // Period 0 clamps to 2
      applyStimulus(1'b1, 32'd0, 1'b0);
      tick();
      cyc = 0;
      advanceTo(1);
      checkOutput("clamp_irq1", {31'd0, irq}, 32'd0);
      checkOutput("clamp_icount1", 32'(icount), 32'd9);
      advanceTo(2);
      checkOutput("clamp_irq2", {31'd0, irq}, 32'd1);
      checkOutput("clamp_icount2", 32'(icount), 32'd10);
      advanceTo(5);
      checkOutput("clamp_icount5", 32'(icount), 32'd11);
      advanceTo(6);
      checkOutput("clamp_icount6", 32'(icount), 32'd12);
      checkOutput("clamp_ovr6", 32'(overrun_count), 32'(ovrExp(3)));
      applyStimulus(1'b0, 32'd0, 1'b0);
      tick();

      // Live period change 20 -> 5 mid-count
      applyStimulus(1'b1, 32'd20, 1'b0);
      tick();
      cyc = 0;
      advanceTo(5);
      period = 32'd5;
      advanceTo(19);
      checkOutput("live_irq19", {31'd0, irq}, 32'd0);
      checkOutput("live_icount19", 32'(icount), 32'd12);
      advanceTo(20);
      checkOutput("live_irq20", {31'd0, irq}, 32'd1);
      checkOutput("live_icount20", 32'(icount), 32'd13);
      advanceTo(24);
      checkOutput("live_icount24", 32'(icount), 32'd13);
      advanceTo(25);
      checkOutput("live_icount25", 32'(icount), 32'd14);
      advanceTo(30);
      checkOutput("live_icount30", 32'(icount), 32'd15);
      checkOutput("live_ovr30", 32'(overrun_count), 32'(ovrExp(5)));
      applyStimulus(1'b0, 32'd5, 1'b0);
      tick();

      // Period 4, never acked: icount wraps, overrun saturates
      applyStimulus(1'b1, 32'd4, 1'b0);
      tick();
      cyc = 0;
      advanceTo(960);
      checkOutput("wrap_icount960", 32'(icount), 32'd255);
      checkOutput("wrap_ovr960", 32'(overrun_count), 32'(ovrExp(244)));
      advanceTo(964);
      checkOutput("wrap_icount964", 32'(icount), 32'd0);
      checkOutput("wrap_irq964", {31'd0, irq}, 32'd1);
      advanceTo(1000);
      checkOutput("wrap_ovr1000", 32'(overrun_count), 32'(ovrExp(254)));
      advanceTo(1004);
      checkOutput("wrap_ovr1004", 32'(overrun_count), 32'(ovrExp(255)));
      advanceTo(1008);
      checkOutput("wrap_ovr1008", 32'(overrun_count), 32'(ovrExp(255)));
      checkOutput("wrap_icount1008", 32'(icount), 32'd11);
      advanceTo(1200);
      checkOutput("wrap_icount1200", 32'(icount), 32'd59);
      checkOutput("wrap_irq1200", {31'd0, irq}, 32'd1);
      checkOutput("wrap_ovr1200", 32'(overrun_count), 32'(ovrExp(255)));

      // Asynchronous reset between clock edges while running
      #3;
      axi_aresetn = 1'b0;
      #1;
      checkOutput("arst_irq", {31'd0, irq}, 32'd0);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_icount", 32'(icount), 32'd0);
      checkOutput("arst_ovr", 32'(overrun_count), 32'd0);
      applyStimulus(1'b0, 32'd4, 1'b0);
      #2;
      axi_aresetn = 1'b1;
      tick();
      checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("post_rst_irq", {31'd0, irq}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
